// File: rtl/rs_pkg.sv
// Shared GF(2^5) definitions for the RS(31,k) decoder front end.
// Contents: field constants, the sequencer state type, and alpha^i helpers.
package rs_pkg;

    localparam int                GF_W     = 5;
    localparam int                GF_ORDER = 31;
    localparam logic [GF_W:0]     GF_POLY  = 6'b100101;  // x^5 + x^2 + 1

    typedef enum logic [1:0] {
        ACCEPT,
        UPDATE,
        DONE
    } state_e;

    // Multiply by alpha = x, reducing modulo the field polynomial.
    function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] a);
        return {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? GF_POLY[GF_W-1:0] : '0);
    endfunction

    function automatic logic [GF_W-1:0] alpha_pow(input int i);
        logic [GF_W-1:0] p;
        p = GF_W'(1);
        for (int j = 0; j < GF_ORDER; j++) begin
            if (j < i) p = gf_xtime(p);
        end
        return p;
    endfunction

endpackage

// File: rtl/gfadder.sv
// GF(2^5) adder: addition in characteristic 2 is a bitwise XOR.
module gfadder
    import rs_pkg::*;
(
    input  logic [GF_W-1:0] a_i,
    input  logic [GF_W-1:0] b_i,
    output logic [GF_W-1:0] s_o
);

    assign s_o = a_i ^ b_i;

endmodule

// File: rtl/lcpmult.sv
// Combinational GF(2^5) multiplier: MSB-first shift-and-add with reduction
// by the field polynomial at every step.
module lcpmult
    import rs_pkg::*;
(
    input  logic [GF_W-1:0] a_i,
    input  logic [GF_W-1:0] b_i,
    output logic [GF_W-1:0] p_o
);

    logic [GF_W-1:0] acc;

    // NOTE: blocking assignments here build a combinational chain; each loop
    // iteration consumes the previous iteration's value.
    always_comb begin
        acc = '0;
        for (int i = GF_W - 1; i >= 0; i--) begin
            acc = gf_xtime(acc) ^ (b_i[i] ? a_i : '0);
        end
        p_o = acc;
    end

endmodule

// File: rtl/syndrome_scheduler.sv
// RS(31,k) syndrome sequencer: accepts one symbol, then spends N_SYN cycles
// updating one Horner accumulator per cycle through a shared multiplier.
module syndrome_scheduler
    import rs_pkg::*;
#(
    parameter int N_SYM = 31,
    parameter int N_SYN = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [GF_W-1:0]       sym_in,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    output logic [GF_W*N_SYN-1:0] syn_out,
    output logic                  syn_valid,
    input  logic                  syn_ready,
    output logic                  error_free
);

    localparam int K_W   = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam int CNT_W = 5;

    state_e           state_q, state_d;
    logic [GF_W-1:0]  sym_q, sym_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GF_W-1:0]  syn_q [N_SYN];
    logic [GF_W-1:0]  alpha_tab [N_SYN];
    logic [N_SYN-1:0] syn_we;
    logic             syn_clr;
    logic [GF_W-1:0]  mul_a, mul_b, prod, sum;

    for (genvar gi = 0; gi < N_SYN; gi++) begin : g_syn
        assign alpha_tab[gi]              = alpha_pow(gi + 1);
        assign syn_out[GF_W*gi +: GF_W]   = syn_q[gi];
    end

    assign error_free = ~|syn_out;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (k_q == K_W'(i)) begin
                mul_a = syn_q[i];
                mul_b = alpha_tab[i];
            end
        end
    end

    lcpmult u_mult (.a_i(mul_a), .b_i(mul_b), .p_o(prod));
    gfadder u_add  (.a_i(prod),  .b_i(sym_q), .s_o(sum));

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        sym_d     = sym_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        syn_we    = '0;
        syn_clr   = 1'b0;
        sym_ready = 1'b0;
        syn_valid = 1'b0;
        case (state_q)
            ACCEPT: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    sym_d   = sym_in;
                    k_d     = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                for (int i = 0; i < N_SYN; i++) syn_we[i] = (k_q == K_W'(i));
                if (k_q == K_W'(N_SYN - 1)) begin
                    k_d     = '0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_W'(N_SYM - 1)) ? DONE : ACCEPT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                syn_valid = 1'b1;
                if (syn_ready) begin
                    syn_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ACCEPT;
            sym_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the accumulators are ordinary flops, not RAM, so resetting them is
    // cheap and keeps syn_out and error_free defined straight out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SYN; i++) syn_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SYN; i++) begin
                if (syn_clr)        syn_q[i] <= '0;
                else if (syn_we[i]) syn_q[i] <= sum;
            end
        end
    end

endmodule

// File: tb/tb_syndrome_scheduler.sv
// Self-checking bench: direct-sum syndrome model, per-cycle output monitor,
// and literal expectations for the hand-computed blocks.
module tb_syndrome_scheduler;

    localparam int N_SYM = 31;
    localparam int N_SYN = 4;
    localparam int SW    = 5 * N_SYN;

    typedef logic [4:0] blk_t [N_SYM];

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    sym_in;
    logic          sym_valid;
    logic          sym_ready;
    logic [SW-1:0] syn_out;
    logic          syn_valid;
    logic          syn_ready;
    logic          error_free;

    int n_checks = 0;
    int n_err    = 0;

    syndrome_scheduler #(.N_SYM(N_SYM), .N_SYN(N_SYN)) dut (
        .clock      (clock),
        .reset      (reset),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .syn_out    (syn_out),
        .syn_valid  (syn_valid),
        .syn_ready  (syn_ready),
        .error_free (error_free)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: polynomial product then reduction, and direct evaluation
    // S_i = sum over degrees d of r_d * (alpha^i)^d.
    function automatic logic [4:0] gmul(input logic [4:0] a, input logic [4:0] b);
        logic [8:0] p;
        p = '0;
        for (int i = 0; i < 5; i++) if (b[i]) p = p ^ (9'(a) << i);
        for (int i = 8; i >= 5; i--) if (p[i]) p = p ^ (9'b100101 << (i - 5));
        return p[4:0];
    endfunction

    function automatic logic [SW-1:0] model_syn(input blk_t blk);
        logic [SW-1:0] r;
        logic [4:0]    ai, xp, s;
        r = '0;
        for (int i = 1; i <= N_SYN; i++) begin
            ai = 5'h01;
            for (int j = 0; j < i; j++) ai = gmul(ai, 5'h02);
            xp = 5'h01;
            s  = 5'h00;
            for (int n = N_SYM - 1; n >= 0; n--) begin
                s  = s ^ gmul(blk[n], xp);
                xp = gmul(xp, ai);
            end
            r[5*i-5 +: 5] = s;
        end
        return r;
    endfunction

    // Monitor state shared with the stimulus process.
    logic [SW-1:0] exp_q [$];
    blk_t cur_blk;
    int   cur_n          = 0;
    int   cyc            = 0;
    int   last_xfer      = -1;
    int   first_xfer_cyc = 0;
    int   rise_cyc       = 0;
    bit   prev_hs        = 0;
    bit   prev_valid     = 0;

    initial forever begin
        @(negedge clock);
        cyc++;
        if (reset) begin
            exp_q.delete();
            cur_n      = 0;
            last_xfer  = -1;
            prev_hs    = 0;
            prev_valid = 0;
        end else begin
            if (prev_hs) check("ready_after_handshake", 32'({sym_ready, syn_valid}), 32'(2'b10));
            if (syn_valid) begin
                check("sym_ready_in_done", 32'(sym_ready), 32'(0));
                if (exp_q.size() == 0) begin
                    check("syn_valid_unexpected", 32'(syn_valid), 32'(0));
                end else begin
                    check("syn_out", 32'(syn_out), 32'(exp_q[0]));
                    check("error_free", 32'(error_free), 32'(exp_q[0] == '0));
                end
                if (!prev_valid) rise_cyc = cyc;
            end
            if (sym_valid && sym_ready) begin
                if (cur_n == 0) first_xfer_cyc = cyc;
                if (last_xfer >= 0) check("xfer_spacing_ok", 32'(cyc - last_xfer >= N_SYN + 1), 32'(1));
                last_xfer = cyc;
                cur_blk[cur_n] = sym_in;
                cur_n++;
                if (cur_n == N_SYM) begin
                    exp_q.push_back(model_syn(cur_blk));
                    cur_n = 0;
                end
            end
            prev_hs    = syn_valid && syn_ready;
            prev_valid = syn_valid;
            if (prev_hs && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 after n_sym transfers.
    task automatic send_block(input blk_t blk, input bit gapped, input int n_sym);
        int  n     = 0;
        int  guard = 0;
        bit  xfer;
        while (n < n_sym && guard < 4000) begin
            sym_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            sym_in    = sym_valid ? blk[n] : 5'($urandom);
            xfer      = sym_valid && sym_ready;
            @(posedge clock);
            #1;
            if (xfer) n++;
            guard++;
        end
        sym_valid = 1'b0;
        if (n < n_sym) check("send_timeout_symbols", 32'(n), 32'(n_sym));
    endtask

    task automatic collect(input int hold, output logic [SW-1:0] got, output logic ef);
        int guard = 0;
        syn_ready = 1'b0;
        while (!syn_valid && guard < 2000) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (!syn_valid) check("collect_timeout_syn_valid", 32'(syn_valid), 32'(1));
        got = syn_out;
        ef  = error_free;
        repeat (hold) begin
            @(posedge clock);
            #1;
        end
        syn_ready = 1'b1;
        @(posedge clock);
        #1;
        syn_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sym_ready"},  32'(sym_ready),  32'(1));
        check({tag, "_syn_valid"},  32'(syn_valid),  32'(0));
        check({tag, "_syn_out"},    32'(syn_out),    32'(0));
        check({tag, "_error_free"}, 32'(error_free), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t          blk, zero_blk;
        logic [SW-1:0] got;
        logic          ef;

        reset     = 1'b1;
        sym_valid = 1'b0;
        sym_in    = '0;
        syn_ready = 1'b0;
        for (int i = 0; i < N_SYM; i++) zero_blk[i] = 5'h00;

        #12;
        check_reset_outputs("reset");
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;

        // All-zero block with latency check.
        send_block(zero_blk, 1'b0, N_SYM);
        collect(0, got, ef);
        check("zero_syn", 32'(got), 32'(0));
        check("zero_error_free", 32'(ef), 32'(1));
        check("zero_latency", 32'(rise_cyc - first_xfer_cyc), 32'(N_SYM * (1 + N_SYN)));

        // r = x^30; the literal also pins the model.
        blk = zero_blk;
        blk[0] = 5'h01;
        check("model_pin_x30", 32'(model_syn(blk)), 32'({5'h0B, 5'h16, 5'h09, 5'h12}));
        send_block(blk, 1'b0, N_SYM);
        collect(0, got, ef);
        check("x30_syn", 32'(got), 32'({5'h0B, 5'h16, 5'h09, 5'h12}));
        check("x30_error_free", 32'(ef), 32'(0));

        // Constant term only.
        blk = zero_blk;
        blk[N_SYM-1] = 5'h07;
        send_block(blk, 1'b0, N_SYM);
        collect(0, got, ef);
        check("r0_syn", 32'(got), 32'({4{5'h07}}));

        // Backpressure, then an immediate back-to-back block.
        for (int i = 0; i < N_SYM; i++) blk[i] = 5'($urandom);
        send_block(blk, 1'b0, N_SYM);
        collect(10, got, ef);
        check("bp_syn", 32'(got), 32'(model_syn(blk)));
        check("bp_still_valid", 32'(syn_valid), 32'(0));

        for (int i = 0; i < N_SYM; i++) blk[i] = 5'($urandom);
        send_block(blk, 1'b0, N_SYM);
        collect(0, got, ef);
        check("b2b_syn", 32'(got), 32'(model_syn(blk)));

        // Same symbols with random gaps, then further gapped random blocks.
        send_block(blk, 1'b1, N_SYM);
        collect(0, got, ef);
        check("gapped_syn", 32'(got), 32'(model_syn(blk)));

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < N_SYM; i++) blk[i] = 5'($urandom);
            send_block(blk, 1'b1, N_SYM);
            collect(int'($urandom_range(0, 6)), got, ef);
            check("rand_syn", 32'(got), 32'(model_syn(blk)));
        end

        // Reset in the middle of a nonzero block.
        for (int i = 0; i < N_SYM; i++) blk[i] = 5'($urandom_range(1, 31));
        send_block(blk, 1'b0, 12);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("midrst_hold");
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        send_block(zero_blk, 1'b0, N_SYM);
        collect(0, got, ef);
        check("post_reset_syn", 32'(got), 32'(0));
        check("post_reset_error_free", 32'(ef), 32'(1));

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
